// File: rtl/pipe_pkg.sv
// pipe_pkg: shared CPU pipeline constants, result-source encodings and stage bundle layouts
package pipe_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;
    localparam int IFID_W  = 2 * XLEN;
    localparam int IDEX_W  = 9 + 4 * XLEN + 15;
    localparam int EXMEM_W = 1 + 2 + XLEN + 1 + XLEN + 5 + XLEN;
    localparam int MEMWB_W = 1 + 2 + 3 * XLEN + 5;
    // EX/MEM bit order, MSB first: reg_write, result_src, alu_result, mem_write, write_data, rd, pc_plus4
    localparam int EXMEM_PC4_LSB  = 0;
    localparam int EXMEM_RD_LSB   = EXMEM_PC4_LSB + XLEN;
    localparam int EXMEM_WD_LSB   = EXMEM_RD_LSB + 5;
    localparam int EXMEM_MEMW_BIT = EXMEM_WD_LSB + XLEN;
    localparam int EXMEM_ALU_LSB  = EXMEM_MEMW_BIT + 1;
    localparam int EXMEM_RSRC_LSB = EXMEM_ALU_LSB + XLEN;
    localparam int EXMEM_REGW_BIT = EXMEM_RSRC_LSB + 2;
    typedef struct packed {
        logic              reg_write;
        result_src_e       result_src;
        logic [XLEN-1:0]   alu_result;
        logic              mem_write;
        logic [XLEN-1:0]   write_data;
        logic [4:0]        rd;
        logic [XLEN-1:0]   pc_plus4;
    } exmem_t;
endpackage

// File: rtl/pipe_stage_hs_if.sv
// pipe_stage_hs_if: valid/ready/data handshake between two pipeline stages
//   valid  producer holds a valid bundle
//   ready  consumer accepts the bundle this cycle
//   data   packed WIDTH-bit bundle
interface pipe_stage_hs_if import pipe_pkg::*; #(
    parameter int WIDTH = EXMEM_W
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
//   clk, rst  clock, async active-high reset (clears to 0)
//   inc       count one on this edge
//   clr       synchronous clear, wins over inc
//   cnt       current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked pipeline stage register with flush, optional skid entry and bubble counter
//   clk, rst    clock, async active-high reset
//   in_if       upstream handshake (slave): valid, ready, data
//   out_if      downstream handshake (master): valid, ready, data
//   flush       drop every held entry; no capture this cycle
//   bubble_cnt  saturating count of edges with out_valid=0
module pipe_stage_hs import pipe_pkg::*; #(
    parameter int               WIDTH      = EXMEM_W,
    parameter bit               SKID       = 1'b1,
    parameter logic [WIDTH-1:0] RESET_DATA = '0,
    parameter int               CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stage_hs_if.slave     in_if,
    pipe_stage_hs_if.master    out_if,
    input  logic               flush,
    output logic [CNT_W-1:0]   bubble_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             in_fire, out_fire, out_valid, load_main, load_skid;
    assign out_valid     = state != EMPTY;
    assign in_fire       = in_if.valid & in_if.ready;
    assign out_fire      = out_valid & out_if.ready;
    assign out_if.valid  = out_valid;
    assign out_if.data   = out_valid ? main_q : RESET_DATA;
    // Without a skid entry in_fire in ONE implies out_fire, so FULL is unreachable.
    assign state_nxt = flush ? EMPTY
        : (state == EMPTY) ? (in_fire ? ONE : EMPTY)
        : (state == ONE)   ? ((in_fire && !out_fire) ? FULL : (out_fire && !in_fire) ? EMPTY : ONE)
        : (out_fire ? ONE : FULL);
    // Main takes new data when it is free or being drained; skid refills main on drain from FULL.
    assign load_main = !flush && ((in_fire && (!out_valid || out_fire)) || (state == FULL && out_fire));
    assign load_skid = !flush && in_fire && out_valid && !out_fire;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else state <= state_nxt;
    // Payload flops need no reset: out_data is masked while out_valid=0.
    always_ff @(posedge clk) begin
        if (load_main) main_q <= (state == FULL) ? skid_q : in_if.data;
        if (load_skid) skid_q <= in_if.data;
    end
    generate
        if (SKID) begin : g_skid
            logic ready_q;
            always_ff @(posedge clk or posedge rst)
                if (rst) ready_q <= 1'b1;
                else ready_q <= state_nxt != FULL;
            assign in_if.ready = ready_q;
        end else begin : g_direct
            assign in_if.ready = !out_valid || out_if.ready;
        end
    endgenerate
    sat_counter #(.CNT_W(CNT_W)) u_bubble (
        .clk (clk),
        .rst (rst),
        .inc (!out_valid),
        .clr (1'b0),
        .cnt (bubble_cnt)
    );
endmodule
